// File: rtl/display_scan.sv
// display_scan: time-multiplexed driver for an eight-digit seven-segment display.
// Scans d0..d7 onto one shared segment bus with one-hot active-low anodes,
// inserting BLANK dark cycles at the start of every DIV-cycle digit slot.
// Optional feature macro: DISPLAY_SNAPSHOT_EN (latch all digits at frame start).
module display_scan #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    input  logic [7:0] d5,
    input  logic [7:0] d6,
    input  logic [7:0] d7,
    input  logic       enable,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame
);

    localparam logic [15:0] TICK_LAST = 16'(DIV - 1);

    logic [15:0] tick;
    logic [2:0]  idx;
    logic [7:0]  live_pat;
    logic [7:0]  pattern;
    logic        frame_start;
    logic        dark;

    assign frame_start = (idx == 3'd0) && (tick == 16'd0);

    // With BLANK=0 the dark phase vanishes entirely.
    if (BLANK == 0) begin : g_no_blank
        assign dark = 1'b0;
    end else begin : g_blank
        assign dark = (tick < 16'(BLANK));
    end

    // Select the live digit pattern addressed by the current slot.
    always_comb begin
        live_pat = 8'hFF;
        unique case (idx)
            3'd0: live_pat = d0;
            3'd1: live_pat = d1;
            3'd2: live_pat = d2;
            3'd3: live_pat = d3;
            3'd4: live_pat = d4;
            3'd5: live_pat = d5;
            3'd6: live_pat = d6;
            3'd7: live_pat = d7;
            default: live_pat = 8'hFF;
        endcase
    end

`ifdef DISPLAY_SNAPSHOT_EN
    logic [7:0] shadow [8];

    // Capture all digits once per frame so a frame never mixes old and new results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) shadow[i] <= 8'hFF;
        end else if (enable && frame_start) begin
            shadow[0] <= d0;
            shadow[1] <= d1;
            shadow[2] <= d2;
            shadow[3] <= d3;
            shadow[4] <= d4;
            shadow[5] <= d5;
            shadow[6] <= d6;
            shadow[7] <= d7;
        end
    end

    // On the capture edge itself the shadow is stale, so use the values being captured.
    always_comb begin
        pattern = shadow[idx];
        if (frame_start) pattern = live_pat;
    end
`else
    // No shadow: the segment bus follows the live inputs with one cycle of latency.
    always_comb begin
        pattern = live_pat;
    end
`endif

    // Slot counters and registered outputs, all derived from the pre-edge (idx, tick).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick  <= 16'd0;
            idx   <= 3'd0;
            an    <= 8'hFF;
            seg   <= 8'hFF;
            frame <= 1'b0;
        end else if (!enable) begin
            tick  <= 16'd0;
            idx   <= 3'd0;
            an    <= 8'hFF;
            seg   <= 8'hFF;
            frame <= 1'b0;
        end else begin
            if (tick == TICK_LAST) begin
                tick <= 16'd0;
                idx  <= idx + 3'd1;
            end else begin
                tick <= tick + 16'd1;
            end
            if (dark) begin
                an  <= 8'hFF;
                seg <= 8'hFF;
            end else begin
                an  <= ~(8'h01 << idx);
                seg <= pattern;
            end
            frame <= frame_start;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan with DIV=4; dut_a uses BLANK=1, dut_b BLANK=0.
// Expected outputs come from a position-in-frame model driven by the same inputs.
module tb_display_scan;

    localparam int unsigned DIV = 4;
    localparam int unsigned FRAME_LEN = 8 * DIV;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] d [8];
    logic [7:0] an_a, seg_a, an_b, seg_b;
    logic       frame_a, frame_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         pos;
    logic [7:0] shadow [8];
    logic [7:0] e_an_a, e_seg_a, e_an_b, e_seg_b;
    logic       e_frame;
    bit         snap;

    display_scan #(.DIV(DIV), .BLANK(1)) dut_a (
        .clock(clock), .reset(reset),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .enable(enable), .an(an_a), .seg(seg_a), .frame(frame_a)
    );

    display_scan #(.DIV(DIV), .BLANK(0)) dut_b (
        .clock(clock), .reset(reset),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .enable(enable), .an(an_b), .seg(seg_b), .frame(frame_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void model_clear(input bit clr_shadow);
        pos = 0;
        e_an_a = 8'hFF; e_seg_a = 8'hFF; e_an_b = 8'hFF; e_seg_b = 8'hFF;
        e_frame = 1'b0;
        if (clr_shadow) for (int i = 0; i < 8; i++) shadow[i] = 8'hFF;
    endfunction

    // Behaviour at one clock edge, in terms of position within the frame.
    function automatic void model_edge();
        int digit, t;
        logic [7:0] pat;
        if (reset) begin
            model_clear(1'b1);
        end else if (!enable) begin
            model_clear(1'b0);
        end else begin
            digit = pos / DIV;
            t     = pos % DIV;
            if (pos == 0) for (int i = 0; i < 8; i++) shadow[i] = d[i];
            pat = snap ? shadow[digit] : d[digit];
            e_an_b  = ~(8'h01 << digit);
            e_seg_b = pat;
            e_an_a  = (t < 1) ? 8'hFF : e_an_b;
            e_seg_a = (t < 1) ? 8'hFF : pat;
            e_frame = (pos == 0);
            pos = (pos + 1) % FRAME_LEN;
        end
    endfunction

    // Advance one edge and settle; inputs may be changed by the caller afterwards.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            enable = k[0];
            step();
            checks++;
            if ({an_a, seg_a, frame_a, an_b, seg_b, frame_b} !== {8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold k=%0d got an=%h seg=%h fr=%b / an=%h seg=%h fr=%b want FF FF 0",
                         k, an_a, seg_a, frame_a, an_b, seg_b, frame_b);
            end
        end
        enable = 1'b1;
        reset  = 1'b0;
        for (int k = 0; k < 7; k++) step();
        // Reset asserted between edges must clear outputs immediately.
        #2;
        reset = 1'b1;
        model_clear(1'b1);
        #1;
        checks++;
        if ({an_a, seg_a, frame_a, an_b, seg_b, frame_b} !== {8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got an=%h seg=%h fr=%b / an=%h seg=%h fr=%b want FF FF 0",
                     an_a, seg_a, frame_a, an_b, seg_b, frame_b);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        logic [7:0] pats [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        int frames = 0, last_frame = -1, b_dark = 0, b_fe = 0;
        for (int i = 0; i < 8; i++) d[i] = pats[i];
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int k = 1; k <= 2 * FRAME_LEN; k++) begin
            step();
            checks++;
            if ({an_a, seg_a, frame_a, an_b, seg_b, frame_b} !==
                {e_an_a, e_seg_a, e_frame, e_an_b, e_seg_b, e_frame}) begin
                errors++;
                $display("FAIL full_frame edge=%0d got %h %h %b / %h %h %b want %h %h %b / %h %h %b",
                         k, an_a, seg_a, frame_a, an_b, seg_b, frame_b,
                         e_an_a, e_seg_a, e_frame, e_an_b, e_seg_b, e_frame);
            end
            if (frame_a) begin
                if (last_frame >= 0) begin
                    checks++;
                    if (k - last_frame != int'(FRAME_LEN)) begin
                        errors++;
                        $display("FAIL frame_period got %0d want %0d", k - last_frame, FRAME_LEN);
                    end
                end
                last_frame = k;
                frames++;
            end
            if (an_b == 8'hFF) b_dark++;
            if (k <= int'(FRAME_LEN) && an_b == 8'hFE) b_fe++;
            if (k == 1) begin
                checks++;
                if (frame_a !== 1'b1 || an_a !== 8'hFF) begin
                    errors++;
                    $display("FAIL example_edge1 got fr=%b an=%h want 1 FF", frame_a, an_a);
                end
            end
            if (k == 6) begin
                checks++;
                if (an_a !== 8'hFD || seg_a !== 8'hF9) begin
                    errors++;
                    $display("FAIL example_edge6 got an=%h seg=%h want FD F9", an_a, seg_a);
                end
            end
        end
        checks++;
        if (frames != 2) begin
            errors++;
            $display("FAIL frame_count got %0d want 2", frames);
        end
        checks++;
        if (b_dark != 0) begin
            errors++;
            $display("FAIL noblank_dark got %0d dark cycles want 0", b_dark);
        end
        checks++;
        if (b_fe != int'(DIV)) begin
            errors++;
            $display("FAIL noblank_lit got %0d cycles of digit0 want %0d", b_fe, DIV);
        end
    endtask

    task automatic test_enable_gating();
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int k = 0; k < 5 * int'(DIV) + 2; k++) step();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({an_a, seg_a, frame_a, an_b, seg_b, frame_b} !== {8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL gate_dark k=%0d got %h %h %b / %h %h %b want FF FF 0",
                         k, an_a, seg_a, frame_a, an_b, seg_b, frame_b);
            end
        end
        enable = 1'b1;
        step();
        checks++;
        if (frame_a !== 1'b1 || an_a !== 8'hFF || frame_b !== 1'b1) begin
            errors++;
            $display("FAIL gate_restart got fr=%b an=%h frb=%b want 1 FF 1", frame_a, an_a, frame_b);
        end
        step();
        checks++;
        if (an_a !== 8'hFE || seg_a !== d[0] || frame_a !== 1'b0) begin
            errors++;
            $display("FAIL gate_second got an=%h seg=%h fr=%b want FE %h 0", an_a, seg_a, frame_a, d[0]);
        end
    endtask

    task automatic test_mid_frame();
        logic [7:0] want1;
        logic [7:0] got1 = 8'h00, got2 = 8'h00;
        want1 = snap ? 8'hA4 : 8'h80;
        d[2] = 8'hA4;
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int k = 1; k <= 2 * FRAME_LEN; k++) begin
            step();
            if (k == 6) d[2] = 8'h80;
            checks++;
            if ({an_a, seg_a, frame_a, an_b, seg_b, frame_b} !==
                {e_an_a, e_seg_a, e_frame, e_an_b, e_seg_b, e_frame}) begin
                errors++;
                $display("FAIL mid_frame edge=%0d got %h %h %b / %h %h %b want %h %h %b / %h %h %b",
                         k, an_a, seg_a, frame_a, an_b, seg_b, frame_b,
                         e_an_a, e_seg_a, e_frame, e_an_b, e_seg_b, e_frame);
            end
            if (an_a == 8'hFB && k <= int'(FRAME_LEN)) got1 = seg_a;
            if (an_a == 8'hFB && k > int'(FRAME_LEN)) got2 = seg_a;
        end
        checks++;
        if (got1 !== want1) begin
            errors++;
            $display("FAIL mid_frame_same got %h want %h", got1, want1);
        end
        checks++;
        if (got2 !== 8'h80) begin
            errors++;
            $display("FAIL mid_frame_next got %h want 80", got2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) d[$urandom_range(7)] = 8'($urandom);
            if ($urandom_range(39) == 0) enable = ~enable;
            else if (!enable && $urandom_range(3) == 0) enable = 1'b1;
            step();
            checks++;
            if ({an_a, seg_a, frame_a, an_b, seg_b, frame_b} !==
                {e_an_a, e_seg_a, e_frame, e_an_b, e_seg_b, e_frame}) begin
                errors++;
                $display("FAIL random edge=%0d got %h %h %b / %h %h %b want %h %h %b / %h %h %b",
                         k, an_a, seg_a, frame_a, an_b, seg_b, frame_b,
                         e_an_a, e_seg_a, e_frame, e_an_b, e_seg_b, e_frame);
            end
        end
    endtask

    initial begin
`ifdef DISPLAY_SNAPSHOT_EN
        snap = 1'b1;
`else
        snap = 1'b0;
`endif
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 8'hFF;
        model_clear(1'b1);
        test_reset();
        test_full_frame();
        test_enable_gating();
        test_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
